// File: rtl/atomic_rmw_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : atomic_rmw_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one atomic read-modify-
//             write unit among NUM_REQ requesters. One operation outstanding,
//             local completion of NOP/illegal ops, timeout error response.
//  Revision : 1.0  initial release
// ============================================================================
module atomic_rmw_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            rq_valid,
   output logic [NUM_REQ-1:0]            rq_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
   input  logic [NUM_REQ*2-1:0]          rq_op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_data,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_cmp,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_err,
   output logic                          am_req_valid,
   input  logic                          am_req_ready,
   output logic [ADDR_WIDTH-1:0]         am_req_addr,
   output logic [1:0]                    am_req_op,
   output logic [DATA_WIDTH-1:0]         am_req_data,
   output logic [DATA_WIDTH-1:0]         am_req_cmp,
   input  logic                          am_resp_valid,
   input  logic [DATA_WIDTH-1:0]         am_resp_data
);

   localparam int               c_IDX_W    = $clog2(NUM_REQ);
   localparam int               c_CNT_W    = $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
   localparam logic [1:0]       c_OP_NOP   = 2'd0;
   localparam logic [1:0]       c_OP_ILL   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [c_IDX_W-1:0]      r_rr_ptr;
   logic [c_IDX_W-1:0]      r_owner;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [1:0]              r_op;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [DATA_WIDTH-1:0]   r_cmp;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_data;
   logic                    r_rsp_err;

   logic                    w_found;
   logic [c_IDX_W-1:0]      w_cand;
   logic [c_IDX_W-1:0]      w_gnt_idx;
   logic [1:0]              w_gnt_op;
   logic [NUM_REQ-1:0]      w_rq_ready;
   logic                    w_grant;
   logic                    w_capture;
   logic                    w_cnt_clr;
   logic                    w_cnt_inc;
   logic [NUM_REQ-1:0]      w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0]   w_rsp_data_nxt;
   logic                    w_rsp_err_nxt;

   // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && rq_valid[w_cand]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   assign w_gnt_op = rq_op[int'(w_gnt_idx)*2 +: 2];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, grant and response decisions.
   always_comb begin
      w_state_nxt     = r_state;
      w_rq_ready      = '0;
      w_grant         = 1'b0;
      w_capture       = 1'b0;
      w_cnt_clr       = 1'b0;
      w_cnt_inc       = 1'b0;
      w_rsp_valid_nxt = '0;
      w_rsp_data_nxt  = '0;
      w_rsp_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A grant while reset is held would be silently dropped, so
            // never advertise one.
            if (w_found && !rst) begin
               w_grant               = 1'b1;
               w_rq_ready[w_gnt_idx] = 1'b1;
               if (w_gnt_op == c_OP_NOP) begin
                  w_rsp_valid_nxt[w_gnt_idx] = 1'b1;
               end else if (w_gnt_op == c_OP_ILL) begin
                  w_rsp_valid_nxt[w_gnt_idx] = 1'b1;
                  w_rsp_err_nxt              = 1'b1;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (am_req_ready) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (am_resp_valid) begin
               w_rsp_valid_nxt[r_owner] = 1'b1;
               w_rsp_data_nxt           = am_resp_data;
               w_state_nxt              = S_IDLE;
            end else if (r_cnt == c_CNT_LAST) begin
               w_rsp_valid_nxt[r_owner] = 1'b1;
               w_rsp_err_nxt            = 1'b1;
               w_state_nxt              = S_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Pointer, captured request, timeout counter and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_addr      <= '0;
         r_op        <= '0;
         r_data      <= '0;
         r_cmp       <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_rr_ptr <= c_IDX_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
         end
         if (w_capture) begin
            r_owner <= w_gnt_idx;
            r_addr  <= rq_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_op    <= w_gnt_op;
            r_data  <= rq_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_cmp   <= rq_cmp[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         end
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign rq_ready     = w_rq_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_err      = r_rsp_err;
   assign am_req_valid = (r_state == S_ISSUE);
   assign am_req_addr  = r_addr;
   assign am_req_op    = r_op;
   assign am_req_data  = r_data;
   assign am_req_cmp   = r_cmp;

endmodule
`default_nettype wire

// File: tb/tb_atomic_rmw_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_atomic_rmw_arbiter
//  Purpose  : Self-checking bench for atomic_rmw_arbiter with a behavioural
//             atomic unit and an expected-response scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atomic_rmw_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;
   localparam int TIMEOUT    = 8;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_REQ-1:0]            rq_valid;
   logic [NUM_REQ-1:0]            rq_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr;
   logic [NUM_REQ*2-1:0]          rq_op;
   logic [NUM_REQ*DATA_WIDTH-1:0] rq_data;
   logic [NUM_REQ*DATA_WIDTH-1:0] rq_cmp;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          rsp_err;
   logic                          am_req_valid;
   logic                          am_req_ready;
   logic [ADDR_WIDTH-1:0]         am_req_addr;
   logic [1:0]                    am_req_op;
   logic [DATA_WIDTH-1:0]         am_req_data;
   logic [DATA_WIDTH-1:0]         am_req_cmp;
   logic                          am_resp_valid;
   logic [DATA_WIDTH-1:0]         am_resp_data;

   atomic_rmw_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .rq_valid     (rq_valid),
      .rq_ready     (rq_ready),
      .rq_addr      (rq_addr),
      .rq_op        (rq_op),
      .rq_data      (rq_data),
      .rq_cmp       (rq_cmp),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .am_req_valid (am_req_valid),
      .am_req_ready (am_req_ready),
      .am_req_addr  (am_req_addr),
      .am_req_op    (am_req_op),
      .am_req_data  (am_req_data),
      .am_req_cmp   (am_req_cmp),
      .am_resp_valid(am_resp_valid),
      .am_resp_data (am_resp_data)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_idx_q[$];
   int          grant_cyc_q[$];
   int          rsp_cyc_q[$];
   logic [3:0]  last_grant_vec;

   logic [31:0] mem [0:255];
   logic        pend;
   logic [31:0] pend_data;
   logic        unit_ready, unit_silent, inject_late, am_seen;
   int          accept_cyc;
   logic [7:0]  acc_addr;
   logic [1:0]  acc_op;
   logic [31:0] acc_data, acc_cmp;

   int          rem [4];
   logic [3:0]  drop_pend;
   logic [3:0]  stg_en;
   int          stg_n [4];
   logic [1:0]  stg_op [4];
   logic [7:0]  stg_addr [4];
   logic [31:0] stg_data [4];
   logic [31:0] stg_cmp [4];

   int          rsp_cnt, last_rsp_cyc;
   int          n_tests, n_fail;
   int          snap;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic expect_rsp(input int idx, input logic [31:0] d, input logic e);
      exp_t x;
      x.idx  = 2'(idx);
      x.data = d;
      x.err  = e;
      exp_q.push_back(x);
   endtask

   task automatic stage(input int i, input int n, input logic [1:0] op, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] c);
      stg_en[i]   = 1'b1;
      stg_n[i]    = n;
      stg_op[i]   = op;
      stg_addr[i] = a;
      stg_data[i] = d;
      stg_cmp[i]  = c;
   endtask

   task automatic clear_logs();
      grant_idx_q.delete();
      grant_cyc_q.delete();
      rsp_cyc_q.delete();
   endtask

   // One clock cycle: check responses, run the unit model, drive requesters,
   // then record which requester is granted in this cycle.
   task automatic tick();
      exp_t        e;
      logic [31:0] old;
      @(negedge clk);
      if (rsp_valid != '0) begin
         rsp_cnt++;
         last_rsp_cyc = cyc;
         rsp_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("spurious_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_who", 64'(rsp_valid), 64'(4'b0001 << e.idx));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
      if (am_req_valid) am_seen = 1'b1;
      am_resp_valid = 1'b0;
      am_resp_data  = '0;
      if (pend) begin
         am_resp_valid = 1'b1;
         am_resp_data  = pend_data;
         pend          = 1'b0;
      end
      if (inject_late) begin
         am_resp_valid = 1'b1;
         am_resp_data  = 32'hDEAD_BEEF;
      end
      am_req_ready = unit_ready;
      if (am_req_valid && am_req_ready && !rst) begin
         accept_cyc = cyc;
         acc_addr   = am_req_addr;
         acc_op     = am_req_op;
         acc_data   = am_req_data;
         acc_cmp    = am_req_cmp;
         if (!unit_silent) begin
            old = mem[am_req_addr];
            if (am_req_op == 2'd1) mem[am_req_addr] = old + am_req_data;
            else if (am_req_op == 2'd2 && old == am_req_cmp) mem[am_req_addr] = am_req_data;
            pend      = 1'b1;
            pend_data = old;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (drop_pend[i]) begin
            drop_pend[i] = 1'b0;
            rem[i]--;
            if (rem[i] <= 0) rq_valid[i] = 1'b0;
         end
         if (stg_en[i]) begin
            stg_en[i]                        = 1'b0;
            rem[i]                           = stg_n[i];
            rq_valid[i]                      = 1'b1;
            rq_op[i*2 +: 2]                  = stg_op[i];
            rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = stg_addr[i];
            rq_data[i*DATA_WIDTH +: DATA_WIDTH] = stg_data[i];
            rq_cmp[i*DATA_WIDTH +: DATA_WIDTH]  = stg_cmp[i];
         end
      end
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rq_valid[i] && rq_ready[i]) begin
            drop_pend[i]   = 1'b1;
            last_grant_vec = rq_ready;
            grant_idx_q.push_back(i);
            grant_cyc_q.push_back(cyc);
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rq_valid != '0 || stg_en != '0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_rq_ready"},  64'(rq_ready), 64'd0);
      chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({pfx, "_rsp_data"},  64'(rsp_data), 64'd0);
      chk({pfx, "_rsp_err"},   64'(rsp_err), 64'd0);
      chk({pfx, "_am_valid"},  64'(am_req_valid), 64'd0);
      chk({pfx, "_am_addr"},   64'(am_req_addr), 64'd0);
      chk({pfx, "_am_op"},     64'(am_req_op), 64'd0);
      chk({pfx, "_am_data"},   64'(am_req_data), 64'd0);
      chk({pfx, "_am_cmp"},    64'(am_req_cmp), 64'd0);
   endtask

   initial begin
      int ord[4];
      n_tests = 0; n_fail = 0; rsp_cnt = 0; last_rsp_cyc = 0; accept_cyc = 0;
      rst = 1'b1;
      rq_valid = '0; rq_addr = '0; rq_op = '0; rq_data = '0; rq_cmp = '0;
      am_req_ready = 1'b0; am_resp_valid = 1'b0; am_resp_data = '0;
      unit_ready = 1'b1; unit_silent = 1'b0; inject_late = 1'b0; am_seen = 1'b0;
      pend = 1'b0; pend_data = '0; drop_pend = '0; stg_en = '0; last_grant_vec = '0;
      acc_addr = '0; acc_op = '0; acc_data = '0; acc_cmp = '0;
      for (int i = 0; i < 4; i++) begin
         rem[i] = 0; stg_n[i] = 0; stg_op[i] = '0; stg_addr[i] = '0;
         stg_data[i] = '0; stg_cmp[i] = '0;
      end
      for (int a = 0; a < 256; a++) mem[a] = '0;

      // Reset state
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;

      // All four requesters: FETCH_ADD +1 on addr 0
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         stage(i, 1, 2'd1, 8'd0, 32'd1, 32'd0);
         expect_rsp(i, 32'(i), 1'b0);
      end
      drain(100);
      chk("rr4_count", 64'(grant_idx_q.size()), 64'd4);
      for (int i = 0; i < grant_idx_q.size(); i++) chk("rr4_order", 64'(grant_idx_q[i]), 64'(i));
      if (grant_cyc_q.size() == 4) chk("rr4_spacing", 64'(grant_cyc_q[3] - grant_cyc_q[0]), 64'd9);
      chk("rr4_mem", 64'(mem[0]), 64'd4);

      // Requesters 1 and 3 only: alternate
      clear_logs();
      stage(1, 2, 2'd1, 8'd1, 32'd1, 32'd0);
      stage(3, 2, 2'd1, 8'd1, 32'd1, 32'd0);
      expect_rsp(1, 32'd0, 1'b0); expect_rsp(3, 32'd1, 1'b0);
      expect_rsp(1, 32'd2, 1'b0); expect_rsp(3, 32'd3, 1'b0);
      drain(100);
      ord = '{1, 3, 1, 3};
      chk("alt_count", 64'(grant_idx_q.size()), 64'd4);
      for (int i = 0; i < grant_idx_q.size() && i < 4; i++) chk("alt_order", 64'(grant_idx_q[i]), 64'(ord[i]));

      // NOP from 0 and illegal from 3 in consecutive grants
      clear_logs();
      am_seen = 1'b0;
      stage(0, 1, 2'd0, 8'h11, 32'h55, 32'h0);
      stage(3, 1, 2'd3, 8'h22, 32'h66, 32'h0);
      expect_rsp(0, 32'd0, 1'b0);
      expect_rsp(3, 32'd0, 1'b1);
      drain(50);
      chk("nop_grants", 64'(grant_idx_q.size()), 64'd2);
      if (grant_cyc_q.size() == 2 && rsp_cyc_q.size() == 2) begin
         chk("nop_first", 64'(grant_idx_q[0]), 64'd0);
         chk("nop_grant_gap", 64'(grant_cyc_q[1] - grant_cyc_q[0]), 64'd1);
         chk("nop_rsp_lat", 64'(rsp_cyc_q[0] - grant_cyc_q[0]), 64'd1);
         chk("ill_rsp_lat", 64'(rsp_cyc_q[1] - grant_cyc_q[1]), 64'd1);
      end
      chk("nop_no_am", 64'(am_seen), 64'd0);

      // Single FETCH_ADD from requester 2
      clear_logs();
      mem[5] = 32'd10;
      stage(2, 1, 2'd1, 8'd5, 32'd3, 32'd0);
      expect_rsp(2, 32'd10, 1'b0);
      drain(50);
      chk("fa_grant_vec", 64'(last_grant_vec), 64'h4);
      if (grant_cyc_q.size() == 1 && rsp_cyc_q.size() == 1) begin
         chk("fa_accept_lat", 64'(accept_cyc - grant_cyc_q[0]), 64'd1);
         chk("fa_rsp_lat", 64'(rsp_cyc_q[0] - grant_cyc_q[0]), 64'd3);
      end
      chk("fa_am_addr", 64'(acc_addr), 64'd5);
      chk("fa_am_op", 64'(acc_op), 64'd1);
      chk("fa_am_data", 64'(acc_data), 64'd3);
      chk("fa_mem", 64'(mem[5]), 64'd13);

      // CAS from requester 1, then the same CAS again
      mem[9] = 32'd7;
      stage(1, 1, 2'd2, 8'd9, 32'd9, 32'd7);
      expect_rsp(1, 32'd7, 1'b0);
      drain(50);
      chk("cas_am_cmp", 64'(acc_cmp), 64'd7);
      chk("cas_mem", 64'(mem[9]), 64'd9);
      stage(1, 1, 2'd2, 8'd9, 32'd9, 32'd7);
      expect_rsp(1, 32'd9, 1'b0);
      drain(50);
      chk("cas2_mem", 64'(mem[9]), 64'd9);

      // Stall in ISSUE beyond TIMEOUT cycles: no timeout
      mem[7] = 32'd20;
      unit_ready = 1'b0;
      stage(1, 1, 2'd1, 8'd7, 32'd1, 32'd0);
      expect_rsp(1, 32'd20, 1'b0);
      snap = rsp_cnt;
      repeat (16) tick();
      chk("stall_am_valid", 64'(am_req_valid), 64'd1);
      chk("stall_am_addr", 64'(am_req_addr), 64'd7);
      chk("stall_no_rsp", 64'(rsp_cnt), 64'(snap));
      unit_ready = 1'b1;
      drain(50);
      chk("stall_mem", 64'(mem[7]), 64'd21);

      // Silent unit: timeout error, late response dropped, next op normal
      unit_silent = 1'b1;
      stage(2, 1, 2'd1, 8'd6, 32'd2, 32'd0);
      expect_rsp(2, 32'd0, 1'b1);
      drain(60);
      chk("to_latency", 64'(last_rsp_cyc - (accept_cyc + 1)), 64'(TIMEOUT));
      snap = rsp_cnt;
      inject_late = 1'b1;
      tick();
      inject_late = 1'b0;
      repeat (4) tick();
      chk("late_drop", 64'(rsp_cnt), 64'(snap));
      unit_silent = 1'b0;
      mem[6] = 32'd40;
      stage(1, 1, 2'd1, 8'd6, 32'd5, 32'd0);
      expect_rsp(1, 32'd40, 1'b0);
      drain(50);
      chk("post_to_mem", 64'(mem[6]), 64'd45);

      // Reset while in WAIT: op abandoned, pointer back to 0
      unit_silent = 1'b1;
      stage(0, 1, 2'd1, 8'd3, 32'd1, 32'd0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check_idle_outputs("midrst");
      rst = 1'b0;
      unit_silent = 1'b0;
      snap = rsp_cnt;
      repeat (12) tick();
      chk("rst_abandon", 64'(rsp_cnt), 64'(snap));
      clear_logs();
      mem[3] = 32'd0;
      stage(0, 1, 2'd1, 8'd3, 32'd1, 32'd0);
      stage(2, 1, 2'd1, 8'd3, 32'd1, 32'd0);
      expect_rsp(0, 32'd0, 1'b0);
      expect_rsp(2, 32'd1, 1'b0);
      drain(50);
      if (grant_idx_q.size() >= 1) chk("rst_first_grant", 64'(grant_idx_q[0]), 64'd0);
      else chk("rst_grant_count", 64'(grant_idx_q.size()), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound in case a wait never resolves.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
      $fatal(1);
   end

endmodule
`default_nettype wire
